qsys_rst_ctrl: RTL and testbench

// - Power-up/reset sequencer between the clock PLL and the Qsys (Nios II) system.
// - Pulses the PLL reset, waits for a filtered lock, then holds the Qsys reset for a programmed time before release.
// - Recovers from PLL lock loss, retries a bounded number of times, and accepts a CPU soft-reset request.

---
 rtl/qsys_rst_ctrl_pkg.sv | 23 ++
 rtl/qsys_rst_ctrl_sync_2ff.sv | 24 ++
 rtl/qsys_rst_ctrl.sv | 149 ++++++++++++++
 tb/tb_qsys_rst_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_rst_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL / Qsys reset sequencer.
package qsys_rst_ctrl_pkg;

    typedef enum logic [4:0] {
        S_PLL_RST   = 5'b00001,
        S_WAIT_LOCK = 5'b00010,
        S_HOLD      = 5'b00100,
        S_RUN       = 5'b01000,
        S_FAIL      = 5'b10000
    } state_t;

    localparam int RETRY_W = 2;

    // Width of the shared phase counter: must hold the largest phase length.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/qsys_rst_ctrl_sync_2ff.sv
// Generic 1-bit double-flop synchronizer; both stages reset to 0.
module qsys_rst_ctrl_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/qsys_rst_ctrl.sv
// Power-up sequencer: pulses the PLL reset, filters lock, holds the Qsys reset,
// and recovers from lock loss with a bounded number of retries.
module qsys_rst_ctrl
    import qsys_rst_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_FILT    = 8,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int HOLD_CYC     = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
    output logic               pll_areset,
    output logic               qsys_rst_n,
    output logic               sys_ready,
    output logic               lock_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_W  = cnt_w(PLL_RST_CYC, LOCK_TIMEOUT, HOLD_CYC);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [FILT_W-1:0]  FILT_DONE = FILT_W'(LOCK_FILT);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_cnt_clr;
    logic [FILT_W-1:0]  r_filt;
    logic [FILT_W-1:0]  w_filt_nxt;
    logic [FILT_W-1:0]  w_filt_inc;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               r_pll_areset;
    logic               r_qsys_rst_n;
    logic               r_sys_ready;
    logic               r_lock_fail;
    logic               w_lock_s;

    qsys_rst_ctrl_sync_2ff u_lock_sync (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    assign w_filt_inc = (r_filt == FILT_DONE) ? r_filt : r_filt + FILT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_filt_nxt  = r_filt;
        w_retry_nxt = r_retry;
        case (r_state)
            S_PLL_RST: begin
                w_filt_nxt = '0;
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                w_filt_nxt = w_lock_s ? w_filt_inc : '0;
                // A completed lock filter takes priority over a coincident timeout.
                if (r_filt == FILT_DONE) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_clr   = 1'b1;
                    w_filt_nxt  = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_filt_nxt = '0;
                    if (r_retry < RETRY_MAX) begin
                        w_retry_nxt = r_retry + RETRY_W'(1);
                        w_state_nxt = S_PLL_RST;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end
            end
            S_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_clr   = 1'b1;
                    w_retry_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_RUN: begin
                // Lock loss outranks a simultaneous soft reset request.
                if (!w_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_clr   = 1'b1;
                    w_retry_nxt = '0;
                end else if (soft_rst_req) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_FAIL: begin
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_clr   = 1'b1;
                w_filt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_PLL_RST;
            r_cnt        <= '0;
            r_filt       <= '0;
            r_retry      <= '0;
            r_pll_areset <= 1'b1;
            r_qsys_rst_n <= 1'b0;
            r_sys_ready  <= 1'b0;
            r_lock_fail  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_clr ? '0 :
                            (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
            r_filt       <= w_filt_nxt;
            r_retry      <= w_retry_nxt;
            // Outputs decode the next state so they line up with r_state.
            r_pll_areset <= (w_state_nxt == S_PLL_RST);
            r_qsys_rst_n <= (w_state_nxt == S_RUN);
            r_sys_ready  <= (w_state_nxt == S_RUN);
            r_lock_fail  <= (w_state_nxt == S_FAIL);
        end
    end

    assign pll_areset = r_pll_areset;
    assign qsys_rst_n = r_qsys_rst_n;
    assign sys_ready  = r_sys_ready;
    assign lock_fail  = r_lock_fail;
    assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_qsys_rst_ctrl.sv
// Self-checking bench for qsys_rst_ctrl: phase/timestamp reference model plus
// directed scenarios with hand-computed timing.
module tb_qsys_rst_ctrl;

    localparam int PLL_RST_CYC  = 4;
    localparam int LOCK_FILT    = 3;
    localparam int LOCK_TIMEOUT = 50;
    localparam int HOLD_CYC     = 8;
    localparam int MAX_RETRY    = 2;

    localparam int P_PR = 0, P_WL = 1, P_HO = 2, P_RU = 3, P_FA = 4;
    localparam int SEL_ARESET = 0, SEL_RSTN = 1, SEL_READY = 2, SEL_FAIL = 3, SEL_RETRY1 = 4;

    logic       sys_clk;
    logic       sys_rst;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pll_areset;
    logic       qsys_rst_n;
    logic       sys_ready;
    logic       lock_fail;
    logic [1:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state: phase, edge index of phase entry, consecutive-lock run
    int         mt     = 0;
    int         ph     = P_PR;
    int         ent    = 0;
    int         run    = 0;
    logic [1:0] m_retry = 2'd0;
    bit         mvalid = 1'b0;
    logic       hist[$];

    qsys_rst_ctrl #(
        .PLL_RST_CYC  (PLL_RST_CYC),
        .LOCK_FILT    (LOCK_FILT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .HOLD_CYC     (HOLD_CYC),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_areset   (pll_areset),
        .qsys_rst_n   (qsys_rst_n),
        .sys_ready    (sys_ready),
        .lock_fail    (lock_fail),
        .retry_cnt    (retry_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic go(input int p);
        ph  = p;
        ent = mt;
        run = 0;
    endtask

    task automatic model_step();
        logic ls;
        int   el;
        mt++;
        if (sys_rst) begin
            go(P_PR);
            m_retry = 2'd0;
            hist.delete();
            mvalid = 1'b1;
        end else begin
            // synchronized lock seen at this edge = input sampled two edges earlier
            hist.push_back(pll_locked);
            ls = (hist.size() >= 3) ? hist[hist.size() - 3] : 1'b0;
            if (hist.size() > 3) void'(hist.pop_front());
            el = mt - ent;
            case (ph)
                P_PR: if (el == PLL_RST_CYC) go(P_WL);
                P_WL: begin
                    if (run >= LOCK_FILT) go(P_HO);
                    else if (el == LOCK_TIMEOUT) begin
                        if (int'(m_retry) < MAX_RETRY) begin
                            m_retry = m_retry + 2'd1;
                            go(P_PR);
                        end else begin
                            go(P_FA);
                        end
                    end else begin
                        run = ls ? run + 1 : 0;
                    end
                end
                P_HO: begin
                    if (!ls) begin m_retry = 2'd0; go(P_PR); end
                    else if (el == HOLD_CYC) go(P_RU);
                end
                P_RU: begin
                    if (!ls) begin m_retry = 2'd0; go(P_PR); end
                    else if (soft_rst_req) go(P_HO);
                end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    initial forever begin
        @(negedge sys_clk);
        if (mvalid) begin
            check("cyc_pll_areset", pll_areset, ph == P_PR);
            check("cyc_qsys_rst_n", qsys_rst_n, ph == P_RU);
            check("cyc_sys_ready",  sys_ready,  ph == P_RU);
            check("cyc_lock_fail",  lock_fail,  ph == P_FA);
            check("cyc_retry_cnt",  retry_cnt,  m_retry);
        end
    end

    function automatic logic get_sig(input int sel);
        case (sel)
            SEL_ARESET: return pll_areset;
            SEL_RSTN:   return qsys_rst_n;
            SEL_READY:  return sys_ready;
            SEL_FAIL:   return lock_fail;
            SEL_RETRY1: return (retry_cnt == 2'd1);
            default:    return 1'bx;
        endcase
    endfunction

    // Counts falling edges until the selected output reaches val, bounded by maxc.
    task automatic wait_sig(input int sel, input logic val, input int maxc, input string nm,
                            output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (get_sig(sel) !== val && n < maxc);
        if (get_sig(sel) !== val) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout after %0d cycles, got %0b required %0b", nm, n, get_sig(sel), val);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   rises;
        int   rise_n[4];
        logic [1:0] rise_r[4];
        logic prev_ar;
        logic pat[6];

        sys_rst      = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_pll_areset", pll_areset, 1);
        check("rst_qsys_rst_n", qsys_rst_n, 0);
        check("rst_sys_ready",  sys_ready,  0);
        check("rst_lock_fail",  lock_fail,  0);
        check("rst_retry_cnt",  retry_cnt,  0);

        // nominal bring-up
        sys_rst = 1'b0;
        wait_sig(SEL_ARESET, 1'b0, 20, "nom_areset_wait", n);
        check("nom_areset_len", n, 4);
        repeat (5) @(negedge sys_clk);
        pll_locked = 1'b1;
        wait_sig(SEL_READY, 1'b1, 100, "nom_ready_wait", n);
        check("nom_lock_to_run", n, 14);
        check("nom_rst_n_high", qsys_rst_n, 1);

        // one-cycle lock loss in RUN (one cycle already elapsed before the wait)
        pll_locked = 1'b0;
        @(negedge sys_clk);
        pll_locked = 1'b1;
        wait_sig(SEL_RSTN, 1'b0, 5, "loss_rstn_wait", n);
        check("loss_rstn_lat", n, 2);
        check("loss_areset_on", pll_areset, 1);
        wait_sig(SEL_ARESET, 1'b0, 20, "loss_areset_wait", n);
        check("loss_areset_len", n, 4);
        check("loss_retry", retry_cnt, 0);
        wait_sig(SEL_READY, 1'b1, 50, "loss_ready_wait", n);
        check("loss_relock", n, 12);

        // soft reset in RUN
        soft_rst_req = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b0;
        check("soft_rstn_low", qsys_rst_n, 0);
        wait_sig(SEL_RSTN, 1'b1, 20, "soft_wait", n);
        check("soft_low_cycles", n, 8);

        // sys_rst in the middle of HOLD
        soft_rst_req = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midhold_areset", pll_areset, 1);
        check("midhold_rst_n",  qsys_rst_n, 0);
        check("midhold_ready",  sys_ready,  0);
        check("midhold_fail",   lock_fail,  0);
        check("midhold_retry",  retry_cnt,  0);
        sys_rst = 1'b0;
        wait_sig(SEL_READY, 1'b1, 50, "midhold_ready_wait", n);
        check("midhold_restart", n, 16);

        // glitchy lock 1,1,0,1,1,1
        sys_rst    = 1'b1;
        pll_locked = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_sig(SEL_ARESET, 1'b0, 20, "glitch_areset_wait", n);
        check("glitch_areset_len", n, 4);
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        n = 0;
        for (int i = 0; i < 6; i++) begin
            pll_locked = pat[i];
            @(negedge sys_clk);
            n++;
        end
        check("glitch_not_ready", sys_ready, 0);
        begin
            int n2;
            wait_sig(SEL_READY, 1'b1, 50, "glitch_ready_wait", n2);
            check("glitch_lock_to_run", n + n2, 17);
        end

        // lock never arrives; a soft request during WAIT_LOCK must be ignored
        sys_rst    = 1'b1;
        pll_locked = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        rises   = 0;
        n       = 0;
        prev_ar = pll_areset;
        for (int i = 0; i < 4; i++) begin rise_n[i] = 0; rise_r[i] = 2'd0; end
        while (n < 300 && lock_fail !== 1'b1) begin
            soft_rst_req = (n == 10);
            @(negedge sys_clk);
            n++;
            if (pll_areset === 1'b1 && prev_ar === 1'b0 && rises < 4) begin
                rise_n[rises] = n;
                rise_r[rises] = retry_cnt;
                rises++;
            end
            prev_ar = pll_areset;
        end
        soft_rst_req = 1'b0;
        check("to_rises", rises, 2);
        check("to_rise0_time", rise_n[0], 54);
        check("to_rise0_retry", rise_r[0], 1);
        check("to_rise1_time", rise_n[1], 108);
        check("to_rise1_retry", rise_r[1], 2);
        check("to_fail_time", n, 162);
        check("to_fail_rst_n", qsys_rst_n, 0);
        pll_locked   = 1'b1;
        soft_rst_req = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("fail_sticky", lock_fail, 1);
        check("fail_rst_n", qsys_rst_n, 0);
        check("fail_retry", retry_cnt, 2);

        // retry count survives lock and soft reset; soft+loss takes the PLL path
        sys_rst    = 1'b1;
        pll_locked = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_sig(SEL_RETRY1, 1'b1, 100, "keep_retry_wait", n);
        check("keep_retry_time", n, 54);
        pll_locked = 1'b1;
        wait_sig(SEL_READY, 1'b1, 100, "keep_ready_wait", n);
        check("keep_retry_run", retry_cnt, 1);
        soft_rst_req = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b0;
        wait_sig(SEL_RSTN, 1'b1, 20, "keep_soft_wait", n);
        check("keep_retry_soft", retry_cnt, 1);
        pll_locked = 1'b0;
        @(negedge sys_clk);
        pll_locked = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b1;
        @(negedge sys_clk);
        soft_rst_req = 1'b0;
        check("both_areset", pll_areset, 1);
        check("both_retry", retry_cnt, 0);
        check("both_rst_n", qsys_rst_n, 0);
        wait_sig(SEL_READY, 1'b1, 50, "both_ready_wait", n);
        check("both_relock", n, 16);

        repeat (3) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
